sys_ctrl_rf: RTL and testbench
==============================

SYS_CTRL_RF -- requirements
Module: sys_ctrl_rf

Interface
REQ-001 Parameter WIDTH, default 8: register data width.
REQ-002 Parameter ADDR, default 4: register address width.
REQ-003 Parameter TIMEOUT, default 255: maximum idle cycles allowed between bytes of a frame, or while waiting for read data.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx_data_in  input  8  received command byte.
REQ-007 rx_valid_in  input  1  one-cycle strobe, rx_data_in valid.
REQ-008 rf_wr_en_out  output  1  register-file write enable.
REQ-009 rf_rd_en_out  output  1  register-file read enable.
REQ-010 rf_addr_out  output  ADDR  register-file address.
REQ-011 rf_wr_data_out  output  WIDTH  register-file write data.
REQ-012 rf_rd_data_in  input  WIDTH  register-file read data.
REQ-013 rf_rd_valid_in  input  1  register-file read data valid.
REQ-014 tx_data_out  output  8  response byte.
REQ-015 tx_valid_out  output  1  response byte valid.
REQ-016 tx_ready_in  input  1  transmitter accepts the byte on this edge when tx_valid_out=1.
REQ-017 busy_out  output  1  high in every state except IDLE.
REQ-018 err_out  output  1  one-cycle pulse on any frame error.

Function
REQ-019 The FSM SHALL use these states: IDLE, WR_ADDR, WR_DATA, WR_ISSUE, RD_ADDR, RD_ISSUE, RD_WAIT, TX_SEND.
REQ-020 In IDLE, each opcode byte SHALL be handled as follows:
- 0xAA -> WR_ADDR.
- 0xBB -> RD_ADDR.
- Any other byte -> error response (REQ-027).
REQ-021 In WR_ADDR or RD_ADDR, an address byte SHALL be handled as follows:
- Byte value < 2^ADDR: latch its low ADDR bits into rf_addr_out, then go to WR_DATA or RD_ISSUE respectively.
- Byte value >= 2^ADDR: error response, with no register-file access.
REQ-022 In WR_DATA, a data byte accepted on cycle N SHALL be latched into rf_wr_data_out, and rf_wr_en_out SHALL be high for exactly cycle N+1 (WR_ISSUE), after which the FSM returns to IDLE; a write produces no response byte.
REQ-023 RD_ISSUE SHALL assert rf_rd_en_out for exactly one cycle, then enter RD_WAIT.
REQ-024 In RD_WAIT, when rf_rd_valid_in=1, the FSM SHALL capture rf_rd_data_in (zero-extended or truncated to 8 bits) into tx_data_out and enter TX_SEND.
REQ-025 In TX_SEND, tx_valid_out SHALL be high and tx_data_out SHALL be stable until an edge with tx_ready_in=1; tx_valid_out SHALL then drop on the next cycle and the FSM SHALL return to IDLE.
REQ-026 rf_wr_en_out and rf_rd_en_out SHALL never be high in the same cycle, and SHALL be low outside WR_ISSUE and RD_ISSUE respectively.
REQ-027 An error response SHALL:
- pulse err_out for 1 cycle;
- load tx_data_out=0xEE;
- enter TX_SEND.
REQ-028 An 8-bit timeout counter SHALL:
- clear on entry to WR_ADDR, WR_DATA, RD_ADDR or RD_WAIT;
- clear on every accepted byte;
- increment each cycle in those states;
- on reaching TIMEOUT, trigger an error response and abandon the frame with no register-file access.
REQ-029 The counter SHALL saturate and SHALL not wrap.
REQ-030 rx_valid_in SHALL be ignored (the byte dropped) in WR_ISSUE, RD_ISSUE, RD_WAIT and TX_SEND.
REQ-031 If rf_rd_valid_in=1 and the timeout are reached in the same cycle, the valid data SHALL take priority.
REQ-032 An opcode byte received after a completed frame SHALL start a new frame with no idle cycle needed beyond the return to IDLE.

Reset
REQ-033 When reset=1, asynchronously: the FSM SHALL be in IDLE, and all outputs, rf_addr_out, rf_wr_data_out, tx_data_out and the timeout counter SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame without any rf_wr_en_out or rf_rd_en_out pulse; the first byte after reset release is treated as an opcode.

Verification
REQ-035 Bytes AA,03,5C -> one rf_wr_en_out pulse with addr=3 and data=0x5C, the cycle after 0x5C; no tx_valid_out; busy_out returns to 0.
REQ-036 Bytes BB,02 with the register file returning 0x21 one cycle after rf_rd_en_out -> tx_data_out=0x21 held while tx_ready_in=0 for 5 cycles; tx_valid_out drops the cycle after tx_ready_in=1.
REQ-037 Byte 0x7F in IDLE -> err_out pulse, then tx_data_out=0xEE; bytes AA,10 -> error response 0xEE with no write.
REQ-038 Byte AA followed by a gap of TIMEOUT cycles -> err_out pulse and 0xEE; a subsequent BB,01 frame executes normally.
REQ-039 Reset pulse between data byte 0x5C's predecessor (addr) and the data byte -> no write occurs, all outputs 0, FSM in IDLE.
REQ-040 RD_WAIT with rf_rd_valid_in never asserted -> 0xEE after TIMEOUT cycles; a byte sent during TX_SEND is dropped.

Source files
------------

// File: rtl/sys_ctrl_rf.sv
// sys_ctrl_rf: byte-command front end that turns AA (write) / BB (read)
// frames into register-file accesses and answers reads or errors over tx.
// Ports: clk, reset (async, active high); rx_data_in/rx_valid_in command
// bytes; rf_* register-file write/read strobes, address, data and read
// return; tx_data_out/tx_valid_out/tx_ready_in response handshake;
// busy_out (any state but IDLE); err_out (one-cycle frame-error pulse).
module sys_ctrl_rf #(
    parameter int WIDTH   = 8,
    parameter int ADDR    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data_in,
    input  logic             rx_valid_in,
    output logic             rf_wr_en_out,
    output logic             rf_rd_en_out,
    output logic [ADDR-1:0]  rf_addr_out,
    output logic [WIDTH-1:0] rf_wr_data_out,
    input  logic [WIDTH-1:0] rf_rd_data_in,
    input  logic             rf_rd_valid_in,
    output logic [7:0]       tx_data_out,
    output logic             tx_valid_out,
    input  logic             tx_ready_in,
    output logic             busy_out,
    output logic             err_out
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_ISSUE,
        RD_ADDR,
        RD_ISSUE,
        RD_WAIT,
        TX_SEND
    } state_t;

    // The counter is 8 bits wide, so a larger limit behaves as 255.
    localparam logic [7:0] TMO = (TIMEOUT > 255) ? 8'hFF : 8'(TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]       txd_q, txd_d;
    logic             err_q, err_d;

    logic waiting;
    logic timed_out;
    logic addr_ok;
    logic raise_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            txd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            txd_q   <= txd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        txd_d     = txd_q;
        err_d     = 1'b0;
        raise_err = 1'b0;

        waiting   = state_q inside {WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT};
        timed_out = waiting && (cnt_q == TMO);
        addr_ok   = (rx_data_in >> ADDR) == 8'd0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid_in) begin
                    if (rx_data_in == 8'hAA) begin
                        state_d = WR_ADDR;
                    end else if (rx_data_in == 8'hBB) begin
                        state_d = RD_ADDR;
                    end else begin
                        raise_err = 1'b1;
                    end
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (rx_valid_in) begin
                    if (addr_ok) begin
                        addr_d  = ADDR'(rx_data_in);
                        state_d = (state_q == WR_ADDR) ? WR_DATA : RD_ISSUE;
                    end else begin
                        raise_err = 1'b1;
                    end
                end else if (timed_out) begin
                    raise_err = 1'b1;
                end
            end
            WR_DATA: begin
                if (rx_valid_in) begin
                    wdata_d = WIDTH'(rx_data_in);
                    state_d = WR_ISSUE;
                end else if (timed_out) begin
                    raise_err = 1'b1;
                end
            end
            WR_ISSUE: state_d = IDLE;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                // Returned data wins over a timeout landing on the same edge.
                if (rf_rd_valid_in) begin
                    txd_d   = 8'(rf_rd_data_in);
                    state_d = TX_SEND;
                end else if (timed_out) begin
                    raise_err = 1'b1;
                end
            end
            TX_SEND: begin
                if (tx_ready_in) begin
                    state_d = IDLE;
                end
            end
        endcase

        if (raise_err) begin
            state_d = TX_SEND;
            txd_d   = 8'hEE;
            err_d   = 1'b1;
        end

        // Any state change (entry or accepted byte) restarts the count;
        // staying in a waiting state counts up and sticks at all-ones.
        if (waiting && state_d == state_q) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end

    assign rf_wr_en_out   = (state_q == WR_ISSUE);
    assign rf_rd_en_out   = (state_q == RD_ISSUE);
    assign rf_addr_out    = addr_q;
    assign rf_wr_data_out = wdata_q;
    assign tx_data_out    = txd_q;
    assign tx_valid_out   = (state_q == TX_SEND);
    assign busy_out       = (state_q != IDLE);
    assign err_out        = err_q;

endmodule

// File: tb/tb_sys_ctrl_rf.sv
// tb_sys_ctrl_rf: directed frames plus random traffic against a
// frame-level reference model, compared every cycle.
module tb_sys_ctrl_rf;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data_in;
    logic       rx_valid_in;
    logic       rf_wr_en_out;
    logic       rf_rd_en_out;
    logic [3:0] rf_addr_out;
    logic [7:0] rf_wr_data_out;
    logic [7:0] rf_rd_data_in;
    logic       rf_rd_valid_in;
    logic [7:0] tx_data_out;
    logic       tx_valid_out;
    logic       tx_ready_in;
    logic       busy_out;
    logic       err_out;

    always #5 clk = ~clk;

    sys_ctrl_rf #(.WIDTH(8), .ADDR(4), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data_in     (rx_data_in),
        .rx_valid_in    (rx_valid_in),
        .rf_wr_en_out   (rf_wr_en_out),
        .rf_rd_en_out   (rf_rd_en_out),
        .rf_addr_out    (rf_addr_out),
        .rf_wr_data_out (rf_wr_data_out),
        .rf_rd_data_in  (rf_rd_data_in),
        .rf_rd_valid_in (rf_rd_valid_in),
        .tx_data_out    (tx_data_out),
        .tx_valid_out   (tx_valid_out),
        .tx_ready_in    (tx_ready_in),
        .busy_out       (busy_out),
        .err_out        (err_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the frame collected so far plus the pending
    // action (write pulse, read pulse, awaiting data, sending a reply).
    logic [7:0] fr[$];
    bit         m_send, m_wr, m_rd, m_wait, m_err;
    int         m_idle;
    logic [7:0] m_resp, m_addr, m_wdata;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fr.delete();
        m_send = 0; m_wr = 0; m_rd = 0; m_wait = 0; m_err = 0;
        m_idle = 0;
        m_resp = 8'h00; m_addr = 8'h00; m_wdata = 8'h00;
    endtask

    task automatic model_step(input bit rv, input logic [7:0] rd,
                              input bit dv, input logic [7:0] dd,
                              input bit rdy);
        bit collecting;
        bit expired;
        bit fail;
        fail       = 0;
        m_err      = 0;
        collecting = !(m_send || m_wr || m_rd || m_wait);
        expired    = ((collecting && fr.size() != 0) || m_wait) && (m_idle >= TMO);
        if (m_send) begin
            if (rdy) m_send = 0;
        end else if (m_wr) begin
            m_wr = 0;
        end else if (m_rd) begin
            m_rd = 0; m_wait = 1; m_idle = 0;
        end else if (m_wait) begin
            if (dv) begin
                m_resp = dd; m_wait = 0; m_send = 1;
            end else if (expired) fail = 1;
            else m_idle++;
        end else if (rv) begin
            if (fr.size() == 0) begin
                if (rd == 8'hAA || rd == 8'hBB) begin
                    fr.push_back(rd); m_idle = 0;
                end else fail = 1;
            end else if (fr.size() == 1) begin
                if (rd < 8'd16) begin
                    m_addr = rd;
                    if (fr[0] == 8'hAA) begin
                        fr.push_back(rd); m_idle = 0;
                    end else begin
                        fr.delete(); m_rd = 1;
                    end
                end else fail = 1;
            end else begin
                m_wdata = rd; fr.delete(); m_wr = 1;
            end
        end else if (fr.size() != 0) begin
            if (expired) fail = 1;
            else m_idle++;
        end
        if (fail) begin
            fr.delete(); m_wait = 0;
            m_err = 1; m_resp = 8'hEE; m_send = 1;
        end
    endtask

    task automatic compare_all();
        bit exp_busy;
        exp_busy = m_send || m_wr || m_rd || m_wait || (fr.size() != 0);
        chk1("busy", busy_out, exp_busy);
        chk1("wr_en", rf_wr_en_out, m_wr);
        chk1("rd_en", rf_rd_en_out, m_rd);
        chk1("tx_valid", tx_valid_out, m_send);
        chk1("err", err_out, m_err);
        chk8("tx_data", tx_data_out, m_resp);
        if (m_wr || m_rd) chk8("addr", {4'h0, rf_addr_out}, {4'h0, m_addr[3:0]});
        if (m_wr) chk8("wdata", rf_wr_data_out, m_wdata);
    endtask

    task automatic cyc(input bit rv, input logic [7:0] rd,
                       input bit dv, input logic [7:0] dd, input bit rdy);
        rx_valid_in    = rv;
        rx_data_in     = rd;
        rf_rd_valid_in = dv;
        rf_rd_data_in  = dd;
        tx_ready_in    = rdy;
        @(posedge clk);
        model_step(rv, rd, dv, dd, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle_c();
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic ack();
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic zeros_now(input string nm);
        chk1({nm, "_busy"}, busy_out, 1'b0);
        chk1({nm, "_wr"}, rf_wr_en_out, 1'b0);
        chk1({nm, "_rd"}, rf_rd_en_out, 1'b0);
        chk1({nm, "_txv"}, tx_valid_out, 1'b0);
        chk1({nm, "_err"}, err_out, 1'b0);
        chk8({nm, "_txd"}, tx_data_out, 8'h00);
        chk8({nm, "_addr"}, {4'h0, rf_addr_out}, 8'h00);
        chk8({nm, "_wdata"}, rf_wr_data_out, 8'h00);
    endtask

    task automatic rst_pulse();
        reset          = 1'b1;
        rx_valid_in    = 1'b0;
        rf_rd_valid_in = 1'b0;
        tx_ready_in    = 1'b0;
        #1;
        zeros_now("rst_async");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        bit         quiet;
        bit         rv, dv, rdy;
        logic [7:0] rd, dd;
        int         sel;

        reset          = 1'b1;
        rx_valid_in    = 1'b0;
        rx_data_in     = 8'h00;
        rf_rd_valid_in = 1'b0;
        rf_rd_data_in  = 8'h00;
        tx_ready_in    = 1'b0;
        model_reset();
        #1;
        zeros_now("por");
        @(negedge clk);
        reset = 1'b0;
        compare_all();

        // Write AA,03,5C
        send(8'hAA); send(8'h03); send(8'h5C);
        chk1("w_en", rf_wr_en_out, 1'b1);
        chk8("w_addr", {4'h0, rf_addr_out}, 8'h03);
        chk8("w_data", rf_wr_data_out, 8'h5C);
        chk1("w_notx", tx_valid_out, 1'b0);
        idle_c();
        chk1("w_en_off", rf_wr_en_out, 1'b0);
        chk1("w_idle", busy_out, 1'b0);

        // Read BB,02, data one cycle after the read strobe, held reply
        send(8'hBB); send(8'h02);
        chk1("r_en", rf_rd_en_out, 1'b1);
        chk8("r_addr", {4'h0, rf_addr_out}, 8'h02);
        idle_c();
        cyc(1'b0, 8'h00, 1'b1, 8'h21, 1'b0);
        chk1("r_txv", tx_valid_out, 1'b1);
        chk8("r_txd", tx_data_out, 8'h21);
        for (int i = 0; i < 5; i++) begin
            idle_c();
            chk8("r_hold", tx_data_out, 8'h21);
            chk1("r_hold_v", tx_valid_out, 1'b1);
        end
        ack();
        chk1("r_drop", tx_valid_out, 1'b0);

        // Bad opcode, then out-of-range address
        send(8'h7F);
        chk1("op_err", err_out, 1'b1);
        chk8("op_ee", tx_data_out, 8'hEE);
        ack();
        chk1("op_err_1cyc", err_out, 1'b0);
        send(8'hAA); send(8'h10);
        chk1("ad_err", err_out, 1'b1);
        chk8("ad_ee", tx_data_out, 8'hEE);
        chk1("ad_nowr", rf_wr_en_out, 1'b0);
        ack();

        // Gap after opcode: TMO idle cycles tolerated, the next one errors
        send(8'hAA);
        for (int i = 0; i < TMO; i++) idle_c();
        chk1("to_pre_err", err_out, 1'b0);
        chk1("to_pre_busy", busy_out, 1'b1);
        idle_c();
        chk1("to_err", err_out, 1'b1);
        chk8("to_ee", tx_data_out, 8'hEE);
        ack();
        send(8'hBB); send(8'h01);
        chk1("to_rd_en", rf_rd_en_out, 1'b1);
        chk8("to_rd_addr", {4'h0, rf_addr_out}, 8'h01);
        idle_c();
        cyc(1'b0, 8'h00, 1'b1, 8'hC3, 1'b0);
        chk8("to_rd_txd", tx_data_out, 8'hC3);
        ack();

        // Reset between address and data byte
        send(8'hAA); send(8'h03);
        rst_pulse();
        zeros_now("mid_rst");
        send(8'h5C);
        chk1("mid_nowr", rf_wr_en_out, 1'b0);
        chk1("mid_as_op", err_out, 1'b1);
        ack();

        // Read data never returns
        send(8'hBB); send(8'h05); idle_c();
        for (int i = 0; i < TMO; i++) idle_c();
        chk1("rw_pre_txv", tx_valid_out, 1'b0);
        idle_c();
        chk1("rw_err", err_out, 1'b1);
        chk8("rw_ee", tx_data_out, 8'hEE);
        send(8'hAA);
        chk1("rw_drop_txv", tx_valid_out, 1'b1);
        ack();
        chk1("rw_dropped", busy_out, 1'b0);

        // Data arriving on the timeout edge wins
        send(8'hBB); send(8'h06); idle_c();
        for (int i = 0; i < TMO; i++) idle_c();
        cyc(1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
        chk8("prio_txd", tx_data_out, 8'h77);
        chk1("prio_noerr", err_out, 1'b0);
        ack();

        // Random traffic
        quiet = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) quiet = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_pulse();
            end else begin
                rv  = quiet ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 2) == 0);
                sel = int'($urandom_range(0, 9));
                if (sel < 3) rd = 8'hAA;
                else if (sel < 5) rd = 8'hBB;
                else if (sel < 8) rd = 8'($urandom_range(0, 15));
                else rd = 8'($urandom_range(0, 255));
                dv  = quiet ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
                dd  = 8'($urandom_range(0, 255));
                rdy = ($urandom_range(0, 2) == 0);
                cyc(rv, rd, dv, dd, rdy);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
